// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory subsystem.
package lc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    typedef enum logic [2:0] {SelKbsr, SelKbdr, SelDsr, SelDdr, SelMcr, SelNone} mmio_sel_e;

    localparam logic [15:0] KBSR_OFF  = 16'h0000;
    localparam logic [15:0] KBDR_OFF  = 16'h0002;
    localparam logic [15:0] DSR_OFF   = 16'h0004;
    localparam logic [15:0] DDR_OFF   = 16'h0006;
    localparam logic [15:0] MCR_OFF   = 16'h01FE;
    localparam logic [15:0] MCR_RESET = 16'h8000;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 I/O page: keyboard, display and machine-control registers plus read mux.
// Strobes arrive from the controller only in its completion cycle.
module lc3_mmio_regs
    import lc3_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  mmio_sel_e         sel,
    input  logic              stb,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              kb_ready,
    output logic              dsp_valid,
    output logic [7:0]        dsp_data,
    input  logic              dsp_ready,
    output logic              mcr_run
);

    logic              kb_full_q, kb_full_d;
    logic [7:0]        kb_char_q, kb_char_d;
    logic              dsp_valid_q, dsp_valid_d;
    logic [7:0]        dsp_data_q, dsp_data_d;
    logic [DATA_W-1:0] mcr_q, mcr_d;
    logic              kbdr_rd, ddr_wr, mcr_wr;

    assign kbdr_rd = stb && !we && (sel == SelKbdr);
    assign ddr_wr  = stb && we && (sel == SelDdr) && !dsp_valid_q;
    assign mcr_wr  = stb && we && (sel == SelMcr);

    always_comb begin
        kb_full_d   = kb_full_q;
        kb_char_d   = kb_char_q;
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        mcr_d       = mcr_wr ? wdata : mcr_q;
        // A KBDR read wins over a same-cycle capture; the new char lands a cycle later.
        if (kbdr_rd) begin
            kb_full_d = 1'b0;
        end else if (kb_valid && !kb_full_q) begin
            kb_full_d = 1'b1;
            kb_char_d = kb_data;
        end
        if (ddr_wr) begin
            dsp_valid_d = 1'b1;
            dsp_data_d  = wdata[7:0];
        end else if (dsp_valid_q && dsp_ready) begin
            dsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        case (sel)
            SelKbsr: begin
                rdata[15] = kb_full_q;
                err       = we;
            end
            SelKbdr: rdata[7:0] = kb_char_q;
            SelDsr: begin
                rdata[15] = !dsp_valid_q;
                err       = we;
            end
            SelDdr:  err = we && dsp_valid_q;
            SelMcr:  rdata = mcr_q;
            default: err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kb_full_q   <= 1'b0;
            kb_char_q   <= '0;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= '0;
            mcr_q       <= DATA_W'(MCR_RESET);
        end else begin
            kb_full_q   <= kb_full_d;
            kb_char_q   <= kb_char_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
            mcr_q       <= mcr_d;
        end
    end

    assign kb_ready  = !kb_full_q;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
    assign mcr_run   = mcr_q[15];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory subsystem: MAR/MDR, word RAM and I/O page behind a ready handshake
// with configurable wait states.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DEPTH_LOG2  = 12,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(16'hFE00)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     bus_in,
    input  logic                  ld_mar,
    input  logic                  ld_mdr,
    input  logic                  sel_mdr,
    input  logic                  mem_req,
    input  logic                  mem_we,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     mdr_out,
    output logic [ADDR_W-1:0]     mar_out,
    output logic                  addr_err,
    input  logic                  kb_valid,
    input  logic [7:0]            kb_data,
    output logic                  kb_ready,
    output logic                  dsp_valid,
    output logic [7:0]            dsp_data,
    input  logic                  dsp_ready,
    output logic                  mcr_run,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [DATA_W-1:0]     init_data
);

    localparam int unsigned    RAM_WORDS = 2 ** DEPTH_LOG2;
    localparam int unsigned    CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [ADDR_W-1:0]   acc_addr_q;
    logic [DATA_W-1:0]   acc_data_q;
    logic                acc_we_q;
    logic [DATA_W-1:0]   mem_q [RAM_WORDS];

    logic                accept, in_done, is_mmio, is_ram, ram_we, mmio_err;
    logic [ADDR_W-1:0]   mmio_off;
    mmio_sel_e           mmio_sel;
    logic [DATA_W-1:0]   mmio_rdata, ram_rdata, rd_data;

    assign accept  = (state_q == IDLE) && mem_req;
    assign in_done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) state_d = DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The I/O page takes precedence even if RAM would otherwise cover it.
    always_comb begin
        is_mmio  = (acc_addr_q >= MMIO_BASE);
        is_ram   = !is_mmio && ((acc_addr_q >> DEPTH_LOG2) == '0);
        mmio_off = acc_addr_q - MMIO_BASE;
        mmio_sel = SelNone;
        if (is_mmio) begin
            case (mmio_off)
                ADDR_W'(KBSR_OFF): mmio_sel = SelKbsr;
                ADDR_W'(KBDR_OFF): mmio_sel = SelKbdr;
                ADDR_W'(DSR_OFF):  mmio_sel = SelDsr;
                ADDR_W'(DDR_OFF):  mmio_sel = SelDdr;
                ADDR_W'(MCR_OFF):  mmio_sel = SelMcr;
                default:           mmio_sel = SelNone;
            endcase
        end
    end

    assign ram_rdata = mem_q[acc_addr_q[DEPTH_LOG2-1:0]];
    assign rd_data   = is_mmio ? mmio_rdata : (is_ram ? ram_rdata : '0);
    assign ram_we    = in_done && acc_we_q && is_ram;

    always_comb begin
        mar_d = ld_mar ? bus_in[ADDR_W-1:0] : mar_q;
        mdr_d = mdr_q;
        if (ld_mdr) mdr_d = sel_mdr ? (in_done ? rd_data : '0) : bus_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            acc_addr_q <= '0;
            acc_data_q <= '0;
            acc_we_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            if (accept) begin
                acc_addr_q <= mar_q;
                acc_data_q <= mdr_q;
                acc_we_q   <= mem_we;
            end
        end
    end

    // RAM is not reset; backdoor writes only land while the port is fully idle.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[acc_addr_q[DEPTH_LOG2-1:0]] <= acc_data_q;
        end else if (init_we && (state_q == IDLE) && !mem_req) begin
            mem_q[init_addr] <= init_data;
        end
    end

    lc3_mmio_regs #(
        .DATA_W(DATA_W)
    ) u_mmio (
        .clk      (clk),
        .reset    (reset),
        .sel      (mmio_sel),
        .stb      (in_done && is_mmio),
        .we       (acc_we_q),
        .wdata    (acc_data_q),
        .rdata    (mmio_rdata),
        .err      (mmio_err),
        .kb_valid (kb_valid),
        .kb_data  (kb_data),
        .kb_ready (kb_ready),
        .dsp_valid(dsp_valid),
        .dsp_data (dsp_data),
        .dsp_ready(dsp_ready),
        .mcr_run  (mcr_run)
    );

    assign mem_ready = in_done;
    assign addr_err  = in_done && (is_mmio ? mmio_err : !is_ram);
    assign mdr_out   = mdr_q;
    assign mar_out   = mar_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: expected access results are queued at request
// time and checked when mem_ready arrives.
module tb_lc3_mem_ctrl;

    logic        clk, reset;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, sel_mdr, mem_req, mem_we;
    logic        mem_ready, addr_err;
    logic [15:0] mdr_out, mar_out;
    logic        kb_valid, kb_ready, dsp_valid, dsp_ready, mcr_run;
    logic [7:0]  kb_data, dsp_data;
    logic        init_we;
    logic [11:0] init_addr;
    logic [15:0] init_data;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        we;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    lc3_mem_ctrl #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .DEPTH_LOG2 (12),
        .WAIT_CYCLES(2),
        .MMIO_BASE  (16'hFE00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_in   (bus_in),
        .ld_mar   (ld_mar),
        .ld_mdr   (ld_mdr),
        .sel_mdr  (sel_mdr),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_ready(mem_ready),
        .mdr_out  (mdr_out),
        .mar_out  (mar_out),
        .addr_err (addr_err),
        .kb_valid (kb_valid),
        .kb_data  (kb_data),
        .kb_ready (kb_ready),
        .dsp_valid(dsp_valid),
        .dsp_data (dsp_data),
        .dsp_ready(dsp_ready),
        .mcr_run  (mcr_run),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_data(init_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] addr, input logic [15:0] data);
        init_we   = 1'b1;
        init_addr = addr;
        init_data = data;
        tick();
        init_we = 1'b0;
    endtask

    // One complete access; mid_mar perturbs MAR/MDR while the access is in flight.
    task automatic access(input string tag, input logic [15:0] addr, input logic we,
                          input logic [15:0] wdata, input logic [15:0] exp_data,
                          input logic exp_err, input logic mid_mar);
        exp_t e;
        int   lat;
        bus_in = addr;
        ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        if (we) begin
            bus_in  = wdata;
            ld_mdr  = 1'b1;
            sel_mdr = 1'b0;
            tick();
            ld_mdr = 1'b0;
        end
        sb.push_back('{tag, we, exp_data, exp_err});
        mem_req = 1'b1;
        mem_we  = we;
        tick();
        mem_we = ~we;
        lat    = 1;
        if (mid_mar) begin
            bus_in  = addr + 16'd1;
            ld_mar  = 1'b1;
            ld_mdr  = we;
            sel_mdr = 1'b0;
        end
        while (!mem_ready && lat < 20) begin
            tick();
            ld_mar = 1'b0;
            ld_mdr = 1'b0;
            lat++;
        end
        ld_mar = 1'b0;
        check({tag, "_latency"}, lat, 3);
        e = sb.pop_front();
        check({e.tag, "_addr_err"}, addr_err, e.err);
        ld_mdr  = !we;
        sel_mdr = 1'b1;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        ld_mdr  = 1'b0;
        sel_mdr = 1'b0;
        check({e.tag, "_ready_pulse"}, mem_ready, 0);
        if (!e.we) check({e.tag, "_rdata"}, mdr_out, e.data);
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        bus_in    = '0;
        ld_mar    = 0;
        ld_mdr    = 0;
        sel_mdr   = 0;
        mem_req   = 0;
        mem_we    = 0;
        kb_valid  = 0;
        kb_data   = '0;
        dsp_ready = 0;
        init_we   = 0;
        init_addr = '0;
        init_data = '0;
        #1;
        check("rst_mar", mar_out, 0);
        check("rst_mdr", mdr_out, 0);
        check("rst_ready", mem_ready, 0);
        check("rst_err", addr_err, 0);
        check("rst_kb_ready", kb_ready, 1);
        check("rst_dsp_valid", dsp_valid, 0);
        check("rst_dsp_data", dsp_data, 0);
        check("rst_mcr_run", mcr_run, 1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        preload(12'h030, 16'h1234);
        preload(12'h040, 16'h0000);
        preload(12'h041, 16'h5555);
        preload(12'h050, 16'hAAAA);

        access("rd_30", 16'h0030, 0, 0, 16'h1234, 0, 0);
        access("wr_40", 16'h0040, 1, 16'hBEEF, 0, 0, 1);
        check("mid_mar", mar_out, 16'h0041);
        access("rd_40", 16'h0040, 0, 0, 16'hBEEF, 0, 0);
        access("rd_41", 16'h0041, 0, 0, 16'h5555, 0, 0);

        kb_data  = 8'h41;
        kb_valid = 1'b1;
        tick();
        kb_valid = 1'b0;
        check("kb_ready_full", kb_ready, 0);
        access("kbsr_full", 16'hFE00, 0, 0, 16'h8000, 0, 0);
        access("kbdr", 16'hFE02, 0, 0, 16'h0041, 0, 0);
        access("kbsr_empty", 16'hFE00, 0, 0, 16'h0000, 0, 0);
        check("kb_ready_empty", kb_ready, 1);
        access("kbsr_wr", 16'hFE00, 1, 16'hFFFF, 0, 1, 0);

        access("ddr_wr", 16'hFE06, 1, 16'h0048, 0, 0, 0);
        check("dsp_valid_set", dsp_valid, 1);
        check("dsp_data", dsp_data, 8'h48);
        access("dsr_busy", 16'hFE04, 0, 0, 16'h0000, 0, 0);
        access("ddr_drop", 16'hFE06, 1, 16'h0055, 0, 1, 0);
        check("dsp_data_kept", dsp_data, 8'h48);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        check("dsp_valid_clr", dsp_valid, 0);
        access("dsr_idle", 16'hFE04, 0, 0, 16'h8000, 0, 0);

        access("mcr_wr", 16'hFFFE, 1, 16'h0000, 0, 0, 0);
        check("mcr_run_off", mcr_run, 0);
        access("mcr_rd", 16'hFFFE, 0, 0, 16'h0000, 0, 0);
        access("io_hole", 16'hFE10, 0, 0, 16'h0000, 1, 0);
        access("unmapped", 16'h2000, 0, 0, 16'h0000, 1, 0);

        // Abort a write to 0x0050 with reset while it is waiting.
        bus_in = 16'h0050;
        ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        bus_in = 16'h1111;
        ld_mdr = 1'b1;
        tick();
        ld_mdr  = 1'b0;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("abort_ready", mem_ready, 0);
        check("abort_mar", mar_out, 0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mem_ready) seen = 1'b1;
            tick();
        end
        check("abort_no_ready", seen, 0);
        check("abort_mcr_run", mcr_run, 1);
        access("rd_50", 16'h0050, 0, 0, 16'hAAAA, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
